// File: rtl/l2_line_responder.sv
// Responder end of the L1<->L2 line interface: a direct-mapped line store that
// absorbs writebacks immediately and returns read fills after a fixed latency.

package pkg_opengpu;
  localparam int ADDR_WIDTH      = 32;
  localparam int CACHE_LINE_BITS = 512;

  localparam logic [2:0] CACHE_READ      = 3'd0;
  localparam logic [2:0] CACHE_WRITEBACK = 3'd2;
endpackage

module l2_line_responder
  import pkg_opengpu::*;
#(
  parameter int NUM_LINES    = 256,
  parameter int READ_LATENCY = 4,
  parameter int ADDR_W       = ADDR_WIDTH,
  parameter int LINE_W       = CACHE_LINE_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              req_valid,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_rdata,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_errors
);

  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(NUM_LINES);
  // READ_WAIT lasts READ_LATENCY-1 cycles and exits when the counter reads 1.
  localparam logic [7:0] LAT_LOAD = 8'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              acc_read;
  logic              acc_wb;
  logic              acc_err;
  logic [7:0]        lat_cnt;
  logic [LINE_W-1:0] rd_line;
  logic [LINE_W-1:0] store [NUM_LINES];
  logic              unused_addr_bits;

  // Upper address bits alias onto the same line; offset bits are line-internal.
  assign idx              = req_addr[OFF +: IDX_W];
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:OFF+IDX_W], req_addr[OFF-1:0]};

  assign req_ready = (state == IDLE) && !stall && !rst;
  assign accept    = req_valid && req_ready;
  assign acc_read  = accept && (req_type == CACHE_READ);
  assign acc_wb    = accept && (req_type == CACHE_WRITEBACK);
  assign acc_err   = accept && !acc_read && !acc_wb;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    resp_valid = 1'b0;
    resp_rdata = '0;
    case (state)
      IDLE: begin
        if (acc_read) begin
          state_nxt = (READ_LATENCY == 1) ? RESP : READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (lat_cnt == 8'd1) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rd_line;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the line store is built from flops and cleared by reset, so a read
  // after reset always returns a zero line rather than stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt     <= '0;
      rd_line     <= '0;
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_errors <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        store[i] <= '0;
      end
    end else begin
      if (acc_wb) begin
        store[idx]  <= req_wdata;
        stat_writes <= stat_writes + 32'd1;
      end

      if (acc_read) begin
        rd_line    <= store[idx];
        lat_cnt    <= LAT_LOAD;
        stat_reads <= stat_reads + 32'd1;
      end else if (state == READ_WAIT) begin
        lat_cnt <= lat_cnt - 8'd1;
      end

      if (acc_err) begin
        stat_errors <= stat_errors + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_l2_line_responder.sv
// Self-checking bench for l2_line_responder: a cycle-counting behavioural model
// checked every cycle, plus directed scenarios with literal expectations.

module tb_l2_line_responder;

  localparam int LINE_W    = 512;
  localparam int ADDR_W    = 32;
  localparam int NUM_LINES = 256;
  localparam int LAT       = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (READ_LATENCY = 4)
  logic              rst;
  logic              stall;
  logic              req_valid;
  logic [2:0]        req_type;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [LINE_W-1:0] resp_rdata;
  logic [31:0]       stat_reads;
  logic [31:0]       stat_writes;
  logic [31:0]       stat_errors;

  // Second instance (READ_LATENCY = 1)
  logic              r1_rst;
  logic              r1_stall;
  logic              r1_valid;
  logic [2:0]        r1_type;
  logic [ADDR_W-1:0] r1_addr;
  logic [LINE_W-1:0] r1_wdata;
  logic              r1_ready;
  logic              r1_resp_valid;
  logic [LINE_W-1:0] r1_resp_rdata;
  logic [31:0]       r1_reads;
  logic [31:0]       r1_writes;
  logic [31:0]       r1_errors;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  l2_line_responder #(
    .NUM_LINES   (NUM_LINES),
    .READ_LATENCY(LAT),
    .ADDR_W      (ADDR_W),
    .LINE_W      (LINE_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .stat_reads (stat_reads),
    .stat_writes(stat_writes),
    .stat_errors(stat_errors)
  );

  l2_line_responder #(
    .NUM_LINES   (NUM_LINES),
    .READ_LATENCY(1),
    .ADDR_W      (ADDR_W),
    .LINE_W      (LINE_W)
  ) u_lat1 (
    .clk        (clk),
    .rst        (r1_rst),
    .stall      (r1_stall),
    .req_valid  (r1_valid),
    .req_type   (r1_type),
    .req_addr   (r1_addr),
    .req_wdata  (r1_wdata),
    .req_ready  (r1_ready),
    .resp_valid (r1_resp_valid),
    .resp_rdata (r1_resp_rdata),
    .stat_reads (r1_reads),
    .stat_writes(r1_writes),
    .stat_errors(r1_errors)
  );

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks time in cycles: a read accepted in cycle c answers in cycle c+LAT
  // and the responder is free again from cycle c+LAT+1.
  logic [LINE_W-1:0] m_mem [NUM_LINES];
  logic [LINE_W-1:0] m_rd;
  longint            cyc       = 0;
  longint            idle_from = 0;
  longint            resp_at   = -1;
  int unsigned       m_nr      = 0;
  int unsigned       m_nw      = 0;
  int unsigned       m_ne      = 0;

  always @(posedge clk) begin : model
    int idx;
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) m_mem[i] = '0;
      m_rd      = '0;
      m_nr      = 0;
      m_nw      = 0;
      m_ne      = 0;
      idle_from = 0;
      resp_at   = -1;
    end else if (req_valid && !stall && cyc >= idle_from) begin
      idx = int'((req_addr / 64) % NUM_LINES);
      case (req_type)
        3'd2: begin
          m_mem[idx] = req_wdata;
          m_nw++;
        end
        3'd0: begin
          m_rd      = m_mem[idx];
          m_nr++;
          resp_at   = cyc + LAT;
          idle_from = cyc + LAT + 1;
        end
        default: m_ne++;
      endcase
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    logic exp_rv;
    if (chk_en) begin
      exp_rv = !rst && (cyc == resp_at);
      check("m_req_ready", req_ready, !rst && !stall && (cyc >= idle_from));
      check("m_resp_valid", resp_valid, exp_rv);
      check("m_resp_rdata", resp_rdata, exp_rv ? m_rd : '0);
      check("m_stat_reads", stat_reads, rst ? 0 : m_nr);
      check("m_stat_writes", stat_writes, rst ? 0 : m_nw);
      check("m_stat_errors", stat_errors, rst ? 0 : m_ne);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] t, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] d, output int waited);
    logic acc;
    acc       = 1'b0;
    waited    = 0;
    req_valid = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      step();
      if (!acc) waited++;
    end
    req_valid = 1'b0;
    check("accepted", acc, 1'b1);
  endtask

  task automatic read_line(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] exp,
                           input string tag, output int waited);
    logic [LINE_W-1:0] d;
    int   lat;
    int   low;
    logic rdy_back;
    d        = '0;
    lat      = 0;
    low      = 0;
    rdy_back = 1'b0;
    issue(3'd0, a, '0, waited);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (resp_valid && lat == 0) begin
        lat = k;
        d   = resp_rdata;
      end
      if (k <= LAT && !req_ready) low++;
      if (k == LAT + 1) rdy_back = req_ready;
      step();
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_data"}, d, exp);
    check({tag, "_ready_low"}, low, LAT);
    check({tag, "_ready_back"}, rdy_back, 1'b1);
  endtask

  task automatic count_resp(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int w;
    int pulses;
    int acc_cnt;
    logic [31:0] w0;
    logic [31:0] r0;
    logic [LINE_W-1:0] line_a;
    logic [LINE_W-1:0] line_b;
    logic [LINE_W-1:0] line_dead;
    logic [LINE_W-1:0] line_r1;

    line_a    = {16{32'hAAAA_0001}};
    line_b    = {16{32'hBBBB_0002}};
    line_dead = {16{32'hDEAD_BEEF}};
    line_r1   = {16{32'h1234_5678}};

    rst       = 1'b1;
    stall     = 1'b0;
    req_valid = 1'b0;
    req_type  = 3'd0;
    req_addr  = '0;
    req_wdata = '0;
    r1_rst    = 1'b1;
    r1_stall  = 1'b0;
    r1_valid  = 1'b0;
    r1_type   = 3'd0;
    r1_addr   = '0;
    r1_wdata  = '0;

    step();
    chk_en = 1'b1;
    step();
    step();
    rst    = 1'b0;
    r1_rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready_up", req_ready, 1'b1);
    check("rst_reads_zero", stat_reads, 0);
    check("rst_resp_zero", resp_rdata, '0);
    step();

    // Writeback then read of the same line (idx 5)
    issue(3'd2, 32'h0000_0140, line_dead, w);
    read_line(32'h0000_0140, line_dead, "wb_rd", w);
    @(negedge clk);
    check("wb_rd_writes", stat_writes, 1);
    check("wb_rd_reads", stat_reads, 1);
    step();

    // Aliasing: 0x4040 folds onto the same index as 0x40
    issue(3'd2, 32'h0000_0040, line_a, w);
    issue(3'd2, 32'h0000_4040, line_b, w);
    read_line(32'h0000_0040, line_b, "alias", w);

    // Unsupported type: counted, no response, stays ready
    issue(3'd1, 32'h0000_0080, '0, w);
    @(negedge clk);
    check("err_ready", req_ready, 1'b1);
    check("err_count", stat_errors, 1);
    w0 = stat_writes;
    step();
    count_resp(6, pulses);
    check("err_no_resp", pulses, 0);

    // Back-to-back writebacks, one per cycle
    acc_cnt   = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_type  = 3'd2;
      req_addr  = 32'h0000_1000 + 32'(i * 64);
      req_wdata = {16{32'(i + 1)}};
      @(negedge clk);
      if (req_ready) acc_cnt++;
      step();
    end
    req_valid = 1'b0;
    check("b2b_accepts", acc_cnt, 3);
    @(negedge clk);
    check("b2b_writes", stat_writes, w0 + 32'd3);
    step();
    read_line(32'h0000_1040, {16{32'd2}}, "b2b_rd", w);

    // Backpressure: held read under stall is never sampled
    @(negedge clk);
    r0 = stat_reads;
    step();
    stall     = 1'b1;
    req_valid = 1'b1;
    req_type  = 3'd0;
    req_addr  = 32'h0000_4040;
    acc_cnt   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) acc_cnt++;
      step();
    end
    @(negedge clk);
    check("bp_no_ready", acc_cnt, 0);
    check("bp_reads_same", stat_reads, r0);
    step();
    stall = 1'b0;
    read_line(32'h0000_4040, line_b, "bp_rd", w);
    check("bp_release_wait", w, 0);

    // Reset in the middle of READ_WAIT drops the read
    issue(3'd0, 32'h0000_0140, '0, w);
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", req_ready, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_back", req_ready, 1'b1);
    check("rst_mid_writes", stat_writes, 0);
    check("rst_mid_errors", stat_errors, 0);
    step();
    count_resp(6, pulses);
    check("rst_mid_no_resp", pulses, 0);
    read_line(32'h0000_0140, '0, "post_rst", w);
    @(negedge clk);
    check("post_rst_reads", stat_reads, 1);
    step();

    // READ_LATENCY = 1 instance: response in the cycle after accept
    r1_valid = 1'b1;
    r1_type  = 3'd2;
    r1_addr  = 32'h0000_0080;
    r1_wdata = line_r1;
    @(negedge clk);
    check("l1_wb_ready", r1_ready, 1'b1);
    step();
    r1_type  = 3'd0;
    r1_wdata = '0;
    @(negedge clk);
    check("l1_rd_ready", r1_ready, 1'b1);
    step();
    r1_valid = 1'b0;
    @(negedge clk);
    check("l1_resp_valid", r1_resp_valid, 1'b1);
    check("l1_resp_data", r1_resp_rdata, line_r1);
    check("l1_ready_busy", r1_ready, 1'b0);
    step();
    @(negedge clk);
    check("l1_resp_done", r1_resp_valid, 1'b0);
    check("l1_ready_back", r1_ready, 1'b1);
    check("l1_reads", r1_reads, 1);
    check("l1_writes", r1_writes, 1);
    check("l1_errors", r1_errors, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
